// File: rtl/rf_writeback_arbiter.sv
// Arbitrates the register-file write port between the pipeline write-back stage
// and a FIFO of multicycle results; pipeline writes always take the slot.
module rf_writeback_arbiter #(
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wb_en,
    input  logic [3:0]  wb_dest,
    input  logic [31:0] wb_value,
    input  logic        mc_valid,
    input  logic [3:0]  mc_dest,
    input  logic [31:0] mc_value,
    output logic        mc_ready,
    output logic        writeBackEn,
    output logic [3:0]  Dest_wb,
    output logic [31:0] Result_WB,
    output logic        stall_req,
    output logic [14:0] busy_mask,
    output logic        drop_err,
    output logic        proto_err
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [3:0]       dest_mem  [DEPTH];
    logic [31:0]      value_mem [DEPTH];
    logic [DEPTH-1:0] slot_vld;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;
    logic [7:0]       starve_cnt;
    logic             ready_en;

    logic             vld_p1;
    logic [3:0]       dest_p1;
    logic [31:0]      value_p1;

    logic fifo_empty;
    logic wb_live;
    logic mc_fire;
    logic push;
    logic pop;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // ready_en keeps mc_ready low through reset and for the release edge.
    assign fifo_empty = (count == '0);
    assign mc_ready   = ready_en && (count < CNT_W'(DEPTH));
    assign mc_fire    = mc_valid && mc_ready;
    assign push       = mc_fire && (mc_dest != 4'd15);
    assign wb_live    = wb_en && (wb_dest != 4'd15);
    assign pop        = !fifo_empty && !wb_live;
    assign stall_req  = (starve_cnt >= 8'(STARVE_LIMIT));

    assign writeBackEn = vld_p1;
    assign Dest_wb     = dest_p1;
    assign Result_WB   = value_p1;

    always_comb begin
        busy_mask = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (slot_vld[i]) begin
                busy_mask = busy_mask | (15'(1) << dest_mem[i]);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            dest_mem[wr_ptr]  <= mc_dest;
            value_mem[wr_ptr] <= mc_value;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ready_en   <= 1'b0;
            slot_vld   <= '0;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            starve_cnt <= '0;
            drop_err   <= 1'b0;
            proto_err  <= 1'b0;
        end else begin
            ready_en <= 1'b1;
            if (pop) begin
                slot_vld[rd_ptr] <= 1'b0;
                rd_ptr           <= rd_ptr + 1'b1;
            end
            if (push) begin
                slot_vld[wr_ptr] <= 1'b1;
                wr_ptr           <= wr_ptr + 1'b1;
            end
            count <= count + CNT_W'(push) - CNT_W'(pop);
            // The counter only measures how long the current head has waited.
            starve_cnt <= (fifo_empty || pop) ? 8'd0 : sat_inc(starve_cnt);
            if ((wb_en && wb_dest == 4'd15) || (mc_fire && mc_dest == 4'd15)) begin
                drop_err <= 1'b1;
            end
            if (wb_en && stall_req) begin
                proto_err <= 1'b1;
            end
        end
    end

    // Stage p1: registered register-file write port.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_p1   <= 1'b0;
            dest_p1  <= '0;
            value_p1 <= '0;
        end else if (wb_live) begin
            vld_p1   <= 1'b1;
            dest_p1  <= wb_dest;
            value_p1 <= wb_value;
        end else if (!fifo_empty) begin
            vld_p1   <= 1'b1;
            dest_p1  <= dest_mem[rd_ptr];
            value_p1 <= value_mem[rd_ptr];
        end else begin
            vld_p1 <= 1'b0;
        end
    end

endmodule
